// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time, classifies each full
// scan as no key, one key or several keys, debounces the classification over
// consecutive scans and emits a single num_valid pulse per accepted press.

module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] num,
  output logic       num_valid,
  output logic       key_held
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [3:0]        STABLE_CNT = 4'(DEBOUNCE_SCANS);

  // Key codes indexed by image bit position {column, row}.
  localparam logic [3:0] KEYMAP [16] = '{
    4'd1,  4'd4,  4'd7,  4'd14,
    4'd2,  4'd5,  4'd8,  4'd0,
    4'd3,  4'd6,  4'd9,  4'd15,
    4'd10, 4'd11, 4'd12, 4'd13
  };

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_KEY,
    CLS_MULTI
  } cls_kind_t;

  typedef enum logic {
    ST_IDLE,
    ST_PRESSED
  } state_t;

  logic [3:0]        row_meta;
  logic [3:0]        row_s;
  logic [SLOT_W-1:0] slot_cnt;
  logic [1:0]        col_idx;
  logic              slot_end;
  logic              scan_end;
  logic [15:0]       image;
  logic [15:0]       image_full;

  logic [4:0]        bit_cnt;
  logic [3:0]        hit_idx;
  cls_kind_t         cur_kind;
  logic [3:0]        cur_code;

  cls_kind_t         cand_kind;
  logic [3:0]        cand_code;
  logic [3:0]        deb_cnt;
  logic              scan_done;
  logic              stable;

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        num_d;
  logic              num_valid_d;
  logic              key_held_d;

  // Two-flop synchronizer for the asynchronous row inputs; idle rows read high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_s    <= 4'hF;
    end else begin
      row_meta <= row;
      row_s    <= row_meta;
    end
  end

  assign slot_end = (slot_cnt == SLOT_LAST);
  assign scan_end = slot_end && (col_idx == 2'd3);

  // Slot timer and active column index; the column advances at the end of each slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      col_idx  <= 2'd0;
    end else if (slot_end) begin
      slot_cnt <= '0;
      col_idx  <= col_idx + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  assign col = ~(4'b0001 << col_idx);

  // Capture the pressed-row nibble of the active column at the last cycle of its slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      image <= '0;
    end else if (slot_end) begin
      image[{col_idx, 2'b00} +: 4] <= ~row_s;
    end
  end

  // Complete scan image: columns 0..2 from storage, column 3 from the live sample.
  always_comb begin
    image_full        = image;
    image_full[15:12] = ~row_s;
  end

  // Classify the completed scan by how many keys it shows.
  always_comb begin
    bit_cnt = '0;
    hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (image_full[i]) begin
        bit_cnt = bit_cnt + 5'd1;
        hit_idx = 4'(i);
      end
    end
    cur_kind = CLS_NONE;
    cur_code = 4'd0;
    if (bit_cnt == 5'd1) begin
      cur_kind = CLS_KEY;
      cur_code = KEYMAP[hit_idx];
    end else if (bit_cnt > 5'd1) begin
      cur_kind = CLS_MULTI;
    end
  end

  // Count consecutive identical scans, saturating so a held state cannot retrigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_kind <= CLS_NONE;
      cand_code <= 4'd0;
      deb_cnt   <= 4'd0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= scan_end;
      if (scan_end) begin
        if ((cur_kind == cand_kind) && (cur_code == cand_code)) begin
          if (deb_cnt < STABLE_CNT) begin
            deb_cnt <= deb_cnt + 4'd1;
          end
        end else begin
          deb_cnt   <= 4'd1;
          cand_kind <= cur_kind;
          cand_code <= cur_code;
        end
      end
    end
  end

  assign stable = (deb_cnt == STABLE_CNT);

  // Press/release state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accept a stable single key from IDLE; only a stable empty scan releases it.
  always_comb begin
    state_d     = state_q;
    num_d       = num;
    num_valid_d = 1'b0;
    key_held_d  = key_held;
    if (scan_done && stable) begin
      case (state_q)
        ST_IDLE: begin
          if (cand_kind == CLS_KEY) begin
            num_d       = cand_code;
            num_valid_d = 1'b1;
            key_held_d  = 1'b1;
            state_d     = ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          if (cand_kind == CLS_NONE) begin
            key_held_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Registered outputs so num and num_valid change together on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num       <= 4'd0;
      num_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      num       <= num_d;
      num_valid <= num_valid_d;
      key_held  <= key_held_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Drives a simulated 4x4 keypad into keypad_scanner and compares every cycle with a
// scan/debounce model plus hand-computed expectations for each scenario.

module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DS = 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] num;
  logic       num_valid;
  logic       key_held;

  logic [15:0] keys;

  int checks;
  int errors;
  int pulse_cnt;
  bit prev_valid;

  logic [3:0] e_col;
  logic [3:0] e_num;
  logic       e_valid;
  logic       e_held;

  logic [3:0]  m_s1;
  logic [3:0]  m_s2;
  logic [15:0] m_img;
  int          m_t;
  int          m_hist[$];
  bit          m_pending;
  int          m_pcls;

  int keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .row(row),
    .col(col),
    .num(num),
    .num_valid(num_valid),
    .key_held(key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad physics: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!col[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (keys[c*4 + r]) row[r] = 1'b0;
        end
      end
    end
  end

  task automatic mReset();
    m_s1      = 4'hF;
    m_s2      = 4'hF;
    m_img     = '0;
    m_t       = 0;
    m_hist.delete();
    m_pending = 0;
    m_pcls    = -1;
    e_col     = 4'b1110;
    e_num     = 4'd0;
    e_valid   = 1'b0;
    e_held    = 1'b0;
  endtask

  task automatic mStep();
    int slot;
    int cidx;
    int cls;
    int n;
    bit same;
    logic [3:0] one_hot;
    e_valid = 1'b0;
    if (m_pending) begin
      m_pending = 0;
      if (!e_held && m_pcls >= 0 && m_pcls <= 15) begin
        e_num   = 4'(m_pcls);
        e_valid = 1'b1;
        e_held  = 1'b1;
      end else if (e_held && m_pcls == -1) begin
        e_held = 1'b0;
      end
    end
    slot = m_t % SD;
    cidx = (m_t / SD) % 4;
    if (slot == SD - 1) begin
      m_img[cidx*4 +: 4] = ~m_s2;
      if (cidx == 3) begin
        n = $countones(m_img);
        cls = -1;
        if (n > 1) cls = 16;
        else if (n == 1) begin
          for (int b = 0; b < 16; b++) if (m_img[b]) cls = keymap[b % 4][b / 4];
        end
        m_hist.push_back(cls);
        if (m_hist.size() >= DS) begin
          same = 1;
          for (int k = 1; k < DS; k++) if (m_hist[m_hist.size() - 1 - k] != cls) same = 0;
          if (same) begin
            m_pending = 1;
            m_pcls    = cls;
          end
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = row;
    m_t++;
    one_hot = 4'b0001;
    e_col = ~(one_hot << ((m_t / SD) % 4));
  endtask

  // Model advances on each active edge; reset discards everything immediately.
  initial begin
    mReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mReset();
      else mStep();
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle: sample away from the active edge and compare against the model.
  task automatic tick();
    @(negedge clk);
    if (num_valid) pulse_cnt++;
    checkOutput("col", int'(col), int'(e_col));
    checkOutput("num", int'(num), int'(e_num));
    checkOutput("num_valid", int'(num_valid), int'(e_valid));
    checkOutput("key_held", int'(key_held), int'(e_held));
    if (prev_valid) checkOutput("num_valid_back_to_back", int'(num_valid), 0);
    prev_valid = num_valid;
  endtask

  task automatic applyStimulus(input logic [15:0] k, input int ncyc);
    keys = k;
    for (int i = 0; i < ncyc; i++) tick();
  endtask

  function automatic logic [15:0] keyBit(input int r, input int c);
    logic [15:0] v;
    v = '0;
    v[c*4 + r] = 1'b1;
    return v;
  endfunction

  task automatic pressAndMeasure(input int r, input int c, input int code);
    int base;
    int waited;
    bit seen;
    base   = pulse_cnt;
    keys   = keyBit(r, c);
    seen   = 0;
    waited = 0;
    while (!seen && waited < 67) begin
      tick();
      waited++;
      if (num_valid) seen = 1;
    end
    checkOutput("press_latency_within_67", int'(seen), 1);
    applyStimulus(keyBit(r, c), 160 - waited);
    checkOutput("press_pulse_count", pulse_cnt - base, 1);
    checkOutput("press_num", int'(num), code);
    checkOutput("press_key_held", int'(key_held), 1);
    applyStimulus(16'h0000, 80);
    checkOutput("release_key_held", int'(key_held), 0);
  endtask

  initial begin
    int base;
    checks     = 0;
    errors     = 0;
    pulse_cnt  = 0;
    prev_valid = 0;
    keys       = '0;
    rst_n      = 1'b0;

    $display("[TB] reset and column rotation");
    for (int i = 0; i < 3; i++) tick();
    checkOutput("reset_col", int'(col), 4'b1110);
    checkOutput("reset_num", int'(num), 0);
    checkOutput("reset_num_valid", int'(num_valid), 0);
    checkOutput("reset_key_held", int'(key_held), 0);
    rst_n = 1'b1;
    applyStimulus(16'h0000, 4);
    checkOutput("col_step1", int'(col), 4'b1101);
    applyStimulus(16'h0000, 4);
    checkOutput("col_step2", int'(col), 4'b1011);
    applyStimulus(16'h0000, 4);
    checkOutput("col_step3", int'(col), 4'b0111);
    applyStimulus(16'h0000, 4);
    checkOutput("col_step4", int'(col), 4'b1110);
    applyStimulus(16'h0000, 30);

    $display("[TB] single presses 5, #, 0");
    pressAndMeasure(1, 1, 5);
    pressAndMeasure(3, 2, 15);
    pressAndMeasure(3, 1, 0);

    $display("[TB] bouncing 8");
    base = pulse_cnt;
    for (int i = 0; i < 6; i++) applyStimulus((i % 2 == 0) ? keyBit(2, 1) : 16'h0000, 16);
    checkOutput("bounce_no_pulse", pulse_cnt - base, 0);
    applyStimulus(keyBit(2, 1), 64);
    applyStimulus(16'h0000, 80);
    checkOutput("bounce_then_hold_pulses", pulse_cnt - base, 1);
    checkOutput("bounce_num", int'(num), 8);

    $display("[TB] ghosting 1+9 and rollover 3+6");
    base = pulse_cnt;
    applyStimulus(keyBit(0, 0) | keyBit(2, 2), 128);
    checkOutput("multi_no_pulse", pulse_cnt - base, 0);
    checkOutput("multi_num_kept", int'(num), 8);
    checkOutput("multi_not_held", int'(key_held), 0);
    applyStimulus(16'h0000, 64);
    applyStimulus(keyBit(0, 2), 80);
    checkOutput("three_pulse", pulse_cnt - base, 1);
    checkOutput("three_num", int'(num), 3);
    applyStimulus(keyBit(0, 2) | keyBit(1, 2), 80);
    checkOutput("rollover_no_pulse", pulse_cnt - base, 1);
    checkOutput("rollover_held", int'(key_held), 1);
    applyStimulus(16'h0000, 80);

    $display("[TB] release gaps on 7");
    base = pulse_cnt;
    applyStimulus(keyBit(2, 0), 80);
    applyStimulus(16'h0000, 48);
    applyStimulus(keyBit(2, 0), 80);
    applyStimulus(16'h0000, 80);
    checkOutput("long_gap_two_pulses", pulse_cnt - base, 2);
    base = pulse_cnt;
    applyStimulus(keyBit(2, 0), 80);
    applyStimulus(16'h0000, 16);
    checkOutput("short_gap_still_held", int'(key_held), 1);
    applyStimulus(keyBit(2, 0), 80);
    checkOutput("short_gap_one_pulse", pulse_cnt - base, 1);
    checkOutput("short_gap_held_end", int'(key_held), 1);
    applyStimulus(16'h0000, 80);

    $display("[TB] reset while 2 held");
    applyStimulus(keyBit(0, 1), 80);
    checkOutput("pre_reset_held", int'(key_held), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_col", int'(col), 4'b1110);
    checkOutput("async_reset_num", int'(num), 0);
    checkOutput("async_reset_key_held", int'(key_held), 0);
    checkOutput("async_reset_num_valid", int'(num_valid), 0);
    applyStimulus(keyBit(0, 1), 5);
    base = pulse_cnt;
    rst_n = 1'b1;
    applyStimulus(keyBit(0, 1), 80);
    checkOutput("post_reset_pulse", pulse_cnt - base, 1);
    checkOutput("post_reset_num", int'(num), 2);
    applyStimulus(16'h0000, 80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
